scan_doubler: RTL
=================

# scan_doubler

Parametrised line-doubling buffer for the VGA output path. Captures one source scanline of palette-resolved colour at the pixel-write strobe into a ring of `NBUF` line stores and replays the most recently completed line twice at the full clock rate, with optional scanline dimming on the repeat. Sits between the palette RAM output and the VGA DAC. Generalises the fixed two-line ping-pong doubler with configurable pixel width, line length and ring depth, plus stall detection and overflow flags.

## Interface
- `PIXW`, 8: pixel width in bits.
- `LINE_LEN`, 768: maximum pixels stored per source line.
- `NBUF`, 2: number of line stores; power of two, ≥2.
- `DIM_MASK`, 8'h6D: mask applied after a 1-bit right shift to dim a pixel; the default halves each RGB332 field.
- `clk24`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ce_wr`  in  1  write strobe; one pixel is accepted per asserted cycle.
- `wr_line_start`  in  1  one-cycle pulse that begins a new source line.
- `din`  in  PIXW  pixel to write.
- `rd_line_start`  in  1  one-cycle pulse at the start of each output line, derived from the hsync edge.
- `rd_active`  in  1  output visible-area enable.
- `scanline_en`  in  1  when set, the second replay of each line is dimmed.
- `dout`  out  PIXW  registered output pixel.
- `repeat_pulse`  out  1  one-cycle pulse: no new source line was available at a latch point.
- `wr_overflow`  out  1  one-cycle pulse: a write was dropped because the line was full.

## Operation
- **Storage.** `NBUF × LINE_LEN` words of `PIXW` bits in synchronous RAM. The RAM is not reset.
- **Write side state:**
  - `wline`: current store, log2(NBUF) bits.
  - `wcol`: column counter, 0..LINE_LEN.
  - `last_done`: index of the most recently completed store.
- **Write.** When `ce_wr` is set and `wcol < LINE_LEN`: `mem[wline][wcol] <= din` and `wcol++`. When `ce_wr` is set and `wcol == LINE_LEN`: the write is dropped and `wr_overflow` pulses.
- **`wr_line_start` with `wcol != 0`:**
  - `last_done <= wline`
  - `wline <= wline+1` (mod NBUF)
  - `wcol <= 0`
- **`wr_line_start` with `wcol == 0`:** only `wcol <= 0`. An empty line is never committed.
- **`wr_line_start` and `ce_wr` in the same cycle:** the pixel is written to column 0 of the new store, and `wcol` becomes 1.
- **Read side state:**
  - `rline`: store being replayed.
  - `rep`: replay index, 0 or 1.
  - `rcol`: read column.
  - `seen`: the `last_done` value at the previous latch.
- **`rd_line_start`:**
  - `rcol <= 0`
  - `rep <= ~rep`
- **Latch point.** When `rep` is 1 at `rd_line_start` (so the new replay is 0): `rline <= last_done` and `seen <= last_done`. If `last_done == seen`, `repeat_pulse` pulses and the old line is replayed again.
- **Latch sampling.** The latch samples the registered `last_done`. A commit in the same cycle as the latch is not seen until the next latch.
- **Read advance.** Otherwise `rcol` increments in every cycle where `rd_active` is set, saturating at `LINE_LEN`.
- **Output pixel:**
  - `rd_active` low, or `rcol ≥ LINE_LEN` → 0.
  - `rep == 1` with `scanline_en` → `(pix >> 1) & DIM_MASK[PIXW-1:0]`.
  - Otherwise → `pix`.
- **Tearing avoidance.** `wline` never equals `last_done`. With `NBUF ≥ 3` the writer never overwrites `rline` while source and output rates are 1:2. With `NBUF = 2` the design matches the legacy ping-pong behaviour.
- **`reset_n` low (asynchronous, takes effect mid-line):**
  - cleared to 0: `wline`, `wcol`, `rline`, `rep`, `rcol`, `dout`, `repeat_pulse`, `wr_overflow`;
  - set to NBUF-1: `last_done` and `seen`.
  - The first latch after reset therefore pulses `repeat_pulse` unless a line has completed.

## Timing
- **Write.** `din` with `ce_wr` at edge t is written at edge t and is readable from edge t+1.
- **Read pipeline.**
  - `rd_line_start` at edge t → `rcol = 0` after t.
  - RAM is addressed during the cycle after t.
  - `dout` shows pixel 0 after edge t+2, provided `rd_active` was high in the addressing cycle.
- **Read latency.** Address to `dout` is 2 clocks.
- **Pipeline alignment.** `rd_active`, `rep` and `scanline_en` are delayed 1 clock to align with the RAM output.
- **Flags.** `repeat_pulse` and `wr_overflow` are registered and assert for exactly one cycle after the triggering edge.
- **Throughput.**
  - Write: one pixel per `ce_wr`.
  - Read: one pixel per clock.

## Test plan
- **Basic doubling.** `LINE_LEN=8`, `NBUF=2`. Write 8'h10..8'h17 with `ce_wr` every other clock, then `wr_line_start`. Issue two `rd_line_start` with `rd_active` for 8 clocks. Required: `dout` shows 10..17 twice, each starting 2 clocks after the pulse.
- **Scanline dimming.** Same setup with `scanline_en=1` and pixel 8'hFF. Required: first replay shows FF; second replay shows 8'h6D.
- **Source stall.** Complete one line, then issue 4 `rd_line_start` with no further commit. Required: `repeat_pulse` one cycle at the second latch, and the same line is shown on all 4 output lines.
- **Overflow and empty line.**
  - 10 writes into `LINE_LEN=8`: `wr_overflow` pulses twice; `dout` at columns 8–9 is 0.
  - `wr_line_start` with `wcol=0`: `wline` is unchanged.
- **Ring depth and simultaneity.** `NBUF=4`, 5 lines A–E. Required: `wline` wraps 0→3→0. A commit coincident with a latch is replayed only from the following latch. `ce_wr` coincident with `wr_line_start` lands at column 0.
- **Reset mid-line.** Pulse `reset_n` low mid-replay. Required: `dout=0` immediately, all counters 0, and `last_done=NBUF-1`.

Source files
------------

// File: rtl/scan_doubler_if.sv
`default_nettype none
// ============================================================================
// Module      : scan_doubler_if
// Description : Signal bundle between the pixel source / video timing logic
//               and the scan doubler.
//               master : drives the write strobes, pixel data and read timing
//               slave  : the doubler; returns the output pixel and flags
//   ce_wr          write strobe, one pixel per asserted cycle
//   wr_line_start  pulse that begins a new source line
//   din            pixel to write
//   rd_line_start  pulse at the start of each output line
//   rd_active      output visible-area enable
//   scanline_en    dim the second replay of each line
//   dout           registered output pixel
//   repeat_pulse   no new source line was available at a latch point
//   wr_overflow    a write was dropped because the line was full
// Revision    : 1.0 - initial release
// ============================================================================
interface scan_doubler_if #(
  parameter int PIXW = 8
) ();
  logic            ce_wr;
  logic            wr_line_start;
  logic [PIXW-1:0] din;
  logic            rd_line_start;
  logic            rd_active;
  logic            scanline_en;
  logic [PIXW-1:0] dout;
  logic            repeat_pulse;
  logic            wr_overflow;

  modport master (
    output ce_wr, wr_line_start, din, rd_line_start, rd_active, scanline_en,
    input  dout, repeat_pulse, wr_overflow
  );

  modport slave (
    input  ce_wr, wr_line_start, din, rd_line_start, rd_active, scanline_en,
    output dout, repeat_pulse, wr_overflow
  );
endinterface
`default_nettype wire

// File: rtl/scan_doubler.sv
`default_nettype none
// ============================================================================
// Module      : scan_doubler
// Description : Line-doubling buffer. Captures source scanlines into a ring of
//               NBUF line stores and replays the most recently completed line
//               twice at the full clock rate, optionally dimming the repeat.
// Ports       : clk24    system clock
//               reset_n  asynchronous active-low reset
//               bus      scan_doubler_if.slave (write side, read timing,
//                        output pixel and status pulses)
// Parameters  : PIXW, LINE_LEN, NBUF (power of two, >= 2), DIM_MASK
// Revision    : 1.0 - initial release
// ============================================================================
module scan_doubler #(
  parameter int              PIXW     = 8,
  parameter int              LINE_LEN = 768,
  parameter int              NBUF     = 2,
  parameter logic [PIXW-1:0] DIM_MASK = PIXW'(8'h6D)
) (
  input  logic          clk24,
  input  logic          reset_n,
  scan_doubler_if.slave bus
);

  localparam int c_LW = $clog2(NBUF);
  localparam int c_CW = $clog2(LINE_LEN + 1);
  localparam int c_AW = $clog2(NBUF * LINE_LEN);

  localparam logic [c_CW-1:0] c_LEN  = c_CW'(LINE_LEN);
  localparam logic [c_LW-1:0] c_LAST = c_LW'(NBUF - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_LW-1:0] r_wline;
  logic [c_CW-1:0] r_wcol;
  logic [c_LW-1:0] r_last_done;
  logic            r_wr_overflow;

  logic [c_LW-1:0] r_rline;
  logic            r_rep;
  logic [c_CW-1:0] r_rcol;
  logic [c_LW-1:0] r_seen;
  logic            r_repeat_pulse;

  logic [PIXW-1:0] r_mem [NBUF*LINE_LEN];
  logic [PIXW-1:0] r_rdata;
  logic            r_act_d;
  logic            r_rep_d;
  logic            r_sl_d;
  logic [PIXW-1:0] r_dout;

  // --------------------------------------------------------------------------
  // Write-side address generation
  // --------------------------------------------------------------------------
  logic            w_room;
  logic            w_commit;
  logic            w_we;
  logic [c_LW-1:0] w_wr_line;
  logic [c_CW-1:0] w_wr_col;
  logic [c_AW-1:0] w_waddr;

  assign w_room   = (r_wcol < c_LEN);
  // An empty line is never committed, so last_done always names real data.
  assign w_commit = bus.wr_line_start && (r_wcol != '0);
  // A pixel arriving with the line-start pulse belongs to column 0 of the
  // store that the pulse opens.
  assign w_we      = bus.ce_wr && (bus.wr_line_start || w_room);
  assign w_wr_line = w_commit ? (r_wline + c_LW'(1)) : r_wline;
  assign w_wr_col  = bus.wr_line_start ? '0 : r_wcol;
  assign w_waddr   = c_AW'(32'(w_wr_line) * LINE_LEN + 32'(w_wr_col));

  // --------------------------------------------------------------------------
  // Read-side address generation
  // --------------------------------------------------------------------------
  logic            w_rcol_ok;
  logic [c_CW-1:0] w_rcol_a;
  logic [c_AW-1:0] w_raddr;

  assign w_rcol_ok = (r_rcol < c_LEN);
  // rcol saturates at LINE_LEN; clamp so the address stays in range. The
  // output is forced to 0 in that case anyway.
  assign w_rcol_a  = w_rcol_ok ? r_rcol : '0;
  assign w_raddr   = c_AW'(32'(r_rline) * LINE_LEN + 32'(w_rcol_a));

  // --------------------------------------------------------------------------
  // Write side
  // --------------------------------------------------------------------------
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      r_wline       <= '0;
      r_wcol        <= '0;
      r_last_done   <= c_LAST;
      r_wr_overflow <= 1'b0;
    end else begin
      r_wr_overflow <= 1'b0;
      if (bus.wr_line_start) begin
        if (w_commit) begin
          r_last_done <= r_wline;
          r_wline     <= r_wline + c_LW'(1);
        end
        r_wcol <= bus.ce_wr ? c_CW'(1) : '0;
      end else if (bus.ce_wr) begin
        if (w_room) begin
          r_wcol <= r_wcol + c_CW'(1);
        end else begin
          r_wr_overflow <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read side: replay index, column counter and latch of the newest line
  // --------------------------------------------------------------------------
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      r_rline        <= '0;
      r_rep          <= 1'b0;
      r_rcol         <= '0;
      r_seen         <= c_LAST;
      r_repeat_pulse <= 1'b0;
    end else begin
      r_repeat_pulse <= 1'b0;
      if (bus.rd_line_start) begin
        r_rcol <= '0;
        r_rep  <= ~r_rep;
        // Latch only when starting replay 0. The registered last_done is
        // sampled, so a commit on this same edge waits for the next latch.
        if (r_rep) begin
          r_rline        <= r_last_done;
          r_seen         <= r_last_done;
          r_repeat_pulse <= (r_last_done == r_seen);
        end
      end else if (bus.rd_active && w_rcol_ok) begin
        r_rcol <= r_rcol + c_CW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Line store RAM (not reset). Read returns the pre-write contents when both
  // ports hit the same word on one edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk24) begin
    if (w_we) begin
      r_mem[w_waddr] <= bus.din;
    end
    r_rdata <= r_mem[w_raddr];
  end

  // --------------------------------------------------------------------------
  // Output stage: controls delayed one clock to line up with the RAM data
  // --------------------------------------------------------------------------
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      r_act_d <= 1'b0;
      r_rep_d <= 1'b0;
      r_sl_d  <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_act_d <= bus.rd_active && w_rcol_ok;
      r_rep_d <= r_rep;
      r_sl_d  <= bus.scanline_en;
      if (!r_act_d) begin
        r_dout <= '0;
      end else if (r_rep_d && r_sl_d) begin
        r_dout <= (r_rdata >> 1) & DIM_MASK;
      end else begin
        r_dout <= r_rdata;
      end
    end
  end

  assign bus.dout         = r_dout;
  assign bus.repeat_pulse = r_repeat_pulse;
  assign bus.wr_overflow  = r_wr_overflow;

endmodule
`default_nettype wire
